// File: rtl/imem_arbiter.sv
// Instruction memory arbiter: shares one single-port memory between CPU fetch and debug/loader.
// Optional CPU anti-starvation counter enabled by defining IMEM_ARB_FAIRNESS_EN.
`timescale 1ns/1ps
module imem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_sel,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_out
);

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_CPU    = 2'd1,
    OWN_DBG_RD = 2'd2
  } owner_t;

  owner_t            owner;
  logic [ADDR_W-1:0] sel_q;
  logic              force_cpu;

`ifdef IMEM_ARB_FAIRNESS_EN
  localparam int unsigned CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt;

  // CPU overrides debug priority once it has been denied MAX_WAIT times in a row
  assign force_cpu = cpu_req && (wait_cnt == WAIT_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (!cpu_req || cpu_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
`else
  // Strict debug priority; MAX_WAIT only matters when fairness is built in
  assign force_cpu = (MAX_WAIT == 0) && 1'b0;
`endif

  // Same-cycle grant, suppressed while reset is held
  assign dbg_gnt = reset && dbg_req && !force_cpu;
  assign cpu_gnt = reset && cpu_req && (!dbg_req || force_cpu);

  // Memory drive; address parks on the last granted value when idle
  assign mem_sel   = dbg_gnt ? dbg_addr : (cpu_gnt ? cpu_addr : sel_q);
  assign mem_we    = dbg_gnt && dbg_we;
  assign mem_wdata = reset ? dbg_wdata : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sel_q <= '0;
    end else if (cpu_gnt || dbg_gnt) begin
      sel_q <= mem_sel;
    end
  end

  // Owner tag: who gets mem_out on the following cycle (debug writes return nothing)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner <= OWN_NONE;
    end else begin
      case (1'b1)
        cpu_gnt:             owner <= OWN_CPU;
        dbg_gnt && !dbg_we:  owner <= OWN_DBG_RD;
        default:             owner <= OWN_NONE;
      endcase
    end
  end

  assign cpu_rvalid = (owner == OWN_CPU);
  assign dbg_rvalid = (owner == OWN_DBG_RD);
  assign cpu_rdata  = cpu_rvalid ? mem_out : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_out : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a write-first, one-cycle-latency memory model.
`timescale 1ns/1ps
module tb_imem_arbiter;

  logic        clock;
  logic        reset;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic [31:0] mem_sel;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:255];

  imem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_sel(mem_sel), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_out(mem_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Write-first synchronous memory
  always @(posedge clock) begin
    if (mem_we) mem[mem_sel[7:0]] <= mem_wdata;
    mem_out <= mem_we ? mem_wdata : mem[mem_sel[7:0]];
  end

  task automatic drive(input logic cr, input logic [31:0] ca, input logic dr,
                       input logic dw, input logic [31:0] da, input logic [31:0] dd);
    cpu_req = cr; cpu_addr = ca; dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 32'h44, 1'b1, 1'b1, 32'h48, 32'hDEAD_BEEF);
    #12;
    checks++; if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL reset_cpu_gnt got %b exp 0", cpu_gnt); end
    checks++; if (dbg_gnt !== 1'b0) begin errors++; $display("FAIL reset_dbg_gnt got %b exp 0", dbg_gnt); end
    checks++; if (mem_sel !== 32'h0) begin errors++; $display("FAIL reset_mem_sel got %h exp 0", mem_sel); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
    checks++; if ({cpu_rvalid, dbg_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b exp 00", {cpu_rvalid, dbg_rvalid}); end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 reset = 1'b1;
    next_cycle();
    #1;
    checks++; if ({cpu_rvalid, dbg_rvalid} !== 2'b00) begin errors++; $display("FAIL post_reset_rvalid got %b exp 00", {cpu_rvalid, dbg_rvalid}); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [0:2];
    logic [31:0] exp_data [0:2];
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
    exp_data[0] = 32'hC0DE_0000; exp_data[1] = 32'hC0DE_0004; exp_data[2] = 32'hC0DE_0008;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      if (k < 3) drive(1'b1, addrs[k], 1'b0, 1'b0, 32'h0, 32'h0);
      else       drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      if (k < 3) begin
        checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt[%0d] got %b exp 1", k, cpu_gnt); end
        checks++; if (mem_sel !== addrs[k]) begin errors++; $display("FAIL b2b_sel[%0d] got %h exp %h", k, mem_sel, addrs[k]); end
      end
      if (k > 0) begin
        checks++; if (cpu_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_rvalid[%0d] got %b exp 1", k, cpu_rvalid); end
        checks++; if (cpu_rdata !== exp_data[k-1]) begin errors++; $display("FAIL b2b_rdata[%0d] got %h exp %h", k, cpu_rdata, exp_data[k-1]); end
        checks++; if (dbg_rdata !== 32'h0) begin errors++; $display("FAIL b2b_dbg_rdata[%0d] got %h exp 0", k, dbg_rdata); end
      end
    end
    next_cycle();
    #1;
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_tail_rvalid got %b exp 0", cpu_rvalid); end
  endtask

  task automatic test_dbg_write_read();
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'h2402_000A);
    #1;
    checks++; if (dbg_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt got %b exp 1", dbg_gnt); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL wr_we got %b exp 1", mem_we); end
    checks++; if (mem_sel !== 32'h10) begin errors++; $display("FAIL wr_sel got %h exp 10", mem_sel); end
    checks++; if (mem_wdata !== 32'h2402_000A) begin errors++; $display("FAIL wr_wdata got %h exp 2402000a", mem_wdata); end
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rd_we got %b exp 0", mem_we); end
    checks++; if (dbg_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got %b exp 0", dbg_rvalid); end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checks++; if (dbg_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid got %b exp 1", dbg_rvalid); end
    checks++; if (dbg_rdata !== 32'h2402_000A) begin errors++; $display("FAIL rd_rdata got %h exp 2402000a", dbg_rdata); end
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rd_cpu_rvalid got %b exp 0", cpu_rvalid); end
  endtask

  task automatic test_collision();
    next_cycle();
    drive(1'b1, 32'h40, 1'b1, 1'b0, 32'h44, 32'h0);
    #1;
    checks++; if ({dbg_gnt, cpu_gnt} !== 2'b10) begin errors++; $display("FAIL coll_gnts got %b exp 10", {dbg_gnt, cpu_gnt}); end
    checks++; if (mem_sel !== 32'h44) begin errors++; $display("FAIL coll_sel got %h exp 44", mem_sel); end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checks++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'hC0DE_0044) begin errors++; $display("FAIL coll_rdata got %b/%h exp 1/c0de0044", dbg_rvalid, dbg_rdata); end
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL coll_cpu_rvalid got %b exp 0", cpu_rvalid); end
    next_cycle();
  endtask

  task automatic test_fairness();
    logic exp_cpu;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      drive(1'b1, 32'h100, 1'b1, 1'b1, 32'h70, 32'h5);
      #1;
`ifdef IMEM_ARB_FAIRNESS_EN
      exp_cpu = ((i % 5) == 4);
`else
      exp_cpu = 1'b0;
`endif
      checks++; if (cpu_gnt !== exp_cpu) begin errors++; $display("FAIL fair_cpu_gnt[%0d] got %b exp %b", i, cpu_gnt, exp_cpu); end
      checks++; if (dbg_gnt !== !exp_cpu) begin errors++; $display("FAIL fair_dbg_gnt[%0d] got %b exp %b", i, dbg_gnt, !exp_cpu); end
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    next_cycle();
  endtask

  task automatic test_idle_hold();
    next_cycle();
    drive(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL idle_gnt got %b exp 1", cpu_gnt); end
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      checks++; if (mem_sel !== 32'h20) begin errors++; $display("FAIL idle_sel[%0d] got %h exp 20", i, mem_sel); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL idle_we[%0d] got %b exp 0", i, mem_we); end
      checks++; if (cpu_rvalid !== (i == 0)) begin errors++; $display("FAIL idle_rvalid[%0d] got %b exp %b", i, cpu_rvalid, (i == 0)); end
    end
  endtask

  task automatic test_reset_mid_read();
    next_cycle();
    drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL mid_gnt got %b exp 1", cpu_gnt); end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    #1;
    checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin errors++; $display("FAIL mid_rvalid got %b/%h exp 0/0", cpu_rvalid, cpu_rdata); end
    checks++; if (mem_sel !== 32'h0 || mem_we !== 1'b0) begin errors++; $display("FAIL mid_mem got %h/%b exp 0/0", mem_sel, mem_we); end
    #2 reset = 1'b1;
    next_cycle();
    #1;
    checks++; if ({cpu_rvalid, dbg_rvalid} !== 2'b00) begin errors++; $display("FAIL mid_after got %b exp 00", {cpu_rvalid, dbg_rvalid}); end
    checks++; if (mem_sel !== 32'h0) begin errors++; $display("FAIL mid_after_sel got %h exp 0", mem_sel); end
  endtask

  initial begin
    reset = 1'b0;
    mem_out = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    test_reset();
    test_back_to_back();
    test_dbg_write_read();
    test_collision();
    test_fairness();
    test_idle_hold();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
